// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - USB full-speed transmit encoder: SYNC, PID, payload, CRC16, bit stuffing, NRZI and EOP
// Optional macro USB_TX_DATA_TOGGLE_EN enables DATA0/DATA1 alternation.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 4,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [1:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic       clear_toggle,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dplus_out,
    output logic       dminus_out
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]    MAX_LEN  = 7'(MAX_PAYLOAD);
    localparam logic [1:0]    PKT_ACK  = 2'd0;
    localparam logic [1:0]    PKT_NAK  = 2'd1;
    localparam logic [1:0]    PKT_DATA = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_idx;
    logic [7:0]    r_pid;
    logic [7:0]    r_byte;
    logic [6:0]    r_left;
    logic          r_is_data;
    logic [15:0]   r_crc;
    logic [2:0]    r_ones;
    logic          r_line_j;

    state_t        w_nxt_state;
    logic [3:0]    w_nxt_idx;
    logic          w_nxt_bit;
    logic          w_nxt_j;
    logic          w_bit_end;
    logic          w_stuff;
    logic          w_fetch;
    logic          w_crc_fb;
    logic [15:0]   w_crc_nxt;
    logic [3:0]    w_pid_nib;
    logic          w_toggle;
    logic          w_pkt_done;

    assign w_bit_end  = (r_cnt == LAST_CNT);
    assign w_stuff    = (r_ones == 3'd6) && (r_state != S_EOP);
    assign w_fetch    = (w_nxt_state == S_DATA) && (w_nxt_idx == 4'd0);
    assign w_crc_fb   = w_nxt_bit ^ r_crc[15];
    assign w_crc_nxt  = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h8005 : 16'h0000);
    assign w_nxt_j    = w_nxt_bit ? r_line_j : ~r_line_j;
    assign w_pkt_done = (r_state == S_EOP) && w_bit_end && (r_idx == 4'd2);

`ifdef USB_TX_DATA_TOGGLE_EN
    logic r_toggle;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_toggle <= 1'b0;
        end else if (clear_toggle) begin
            r_toggle <= 1'b0;
        end else if (w_pkt_done && r_is_data) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign w_toggle = r_toggle & ~clear_toggle;
`else
    logic w_unused_clear;

    assign w_unused_clear = clear_toggle;
    assign w_toggle       = 1'b0;
`endif

    always_comb begin
        case (tx_packet)
            PKT_ACK:  w_pid_nib = 4'b0010;
            PKT_NAK:  w_pid_nib = 4'b1010;
            PKT_DATA: w_pid_nib = w_toggle ? 4'b1011 : 4'b0011;
            default:  w_pid_nib = 4'b1110;
        endcase
    end

    // Position of the next real (unstuffed) bit after the current one ends.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx + 4'd1;
        case (r_state)
            S_SYNC: if (r_idx == 4'd7) begin
                w_nxt_state = S_PID;
                w_nxt_idx   = 4'd0;
            end
            S_PID: if (r_idx == 4'd7) begin
                w_nxt_idx = 4'd0;
                if (!r_is_data)
                    w_nxt_state = S_EOP;
                else if (r_left != 7'd0)
                    w_nxt_state = S_DATA;
                else
                    w_nxt_state = S_CRC;
            end
            S_DATA: if (r_idx == 4'd7) begin
                w_nxt_idx   = 4'd0;
                w_nxt_state = (r_left != 7'd0) ? S_DATA : S_CRC;
            end
            S_CRC: if (r_idx == 4'd15) begin
                w_nxt_idx   = 4'd0;
                w_nxt_state = S_EOP;
            end
            S_EOP: if (r_idx == 4'd2) begin
                w_nxt_idx   = 4'd0;
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = r_state;
                w_nxt_idx   = r_idx;
            end
        endcase
    end

    // The first payload bit comes straight from the show-ahead head byte.
    always_comb begin
        case (w_nxt_state)
            S_SYNC:  w_nxt_bit = (w_nxt_idx == 4'd7);
            S_PID:   w_nxt_bit = r_pid[w_nxt_idx[2:0]];
            S_DATA:  w_nxt_bit = w_fetch ? tx_packet_data[0] : r_byte[w_nxt_idx[2:0]];
            S_CRC:   w_nxt_bit = ~r_crc[~w_nxt_idx];
            default: w_nxt_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_idx              <= 4'd0;
            r_pid              <= 8'h00;
            r_byte             <= 8'h00;
            r_left             <= 7'd0;
            r_is_data          <= 1'b0;
            r_crc              <= 16'hFFFF;
            r_ones             <= 3'd0;
            r_line_j           <= 1'b1;
            dplus_out          <= 1'b1;
            dminus_out         <= 1'b0;
            tx_transfer_active <= 1'b0;
            tx_error           <= 1'b0;
            get_tx_packet_data <= 1'b0;
        end else begin
            get_tx_packet_data <= 1'b0;
            if (r_state == S_IDLE) begin
                if (tx_start) begin
                    if (tx_packet == PKT_DATA && buffer_occupancy > MAX_LEN) begin
                        tx_error <= 1'b1;
                    end else begin
                        tx_error           <= 1'b0;
                        r_state            <= S_SYNC;
                        r_idx              <= 4'd0;
                        r_cnt              <= '0;
                        r_pid              <= {~w_pid_nib, w_pid_nib};
                        r_is_data          <= (tx_packet == PKT_DATA);
                        r_left             <= (tx_packet == PKT_DATA) ? buffer_occupancy : 7'd0;
                        r_crc              <= 16'hFFFF;
                        r_ones             <= 3'd0;
                        // SYNC starts with a 0, so the line moves from J to K.
                        r_line_j           <= 1'b0;
                        dplus_out          <= 1'b0;
                        dminus_out         <= 1'b1;
                        tx_transfer_active <= 1'b1;
                    end
                end
            end else if (!w_bit_end) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
                if (w_stuff) begin
                    r_ones     <= 3'd0;
                    r_line_j   <= ~r_line_j;
                    dplus_out  <= ~r_line_j;
                    dminus_out <= r_line_j;
                end else begin
                    r_state <= w_nxt_state;
                    r_idx   <= w_nxt_idx;
                    case (w_nxt_state)
                        S_EOP: begin
                            dplus_out  <= (w_nxt_idx == 4'd2);
                            dminus_out <= 1'b0;
                            r_line_j   <= 1'b1;
                        end
                        S_IDLE: begin
                            dplus_out          <= 1'b1;
                            dminus_out         <= 1'b0;
                            tx_transfer_active <= 1'b0;
                        end
                        default: begin
                            r_ones     <= w_nxt_bit ? r_ones + 3'd1 : 3'd0;
                            r_line_j   <= w_nxt_j;
                            dplus_out  <= w_nxt_j;
                            dminus_out <= ~w_nxt_j;
                        end
                    endcase
                    if (w_fetch) begin
                        r_byte             <= tx_packet_data;
                        r_left             <= r_left - 7'd1;
                        get_tx_packet_data <= 1'b1;
                    end
                    if (w_nxt_state == S_DATA)
                        r_crc <= w_crc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb/tb_usb_tx_encoder.sv - table-driven scoreboard bench for usb_tx_encoder
module tb_usb_tx_encoder;

    localparam int CPB = 4;

`ifdef USB_TX_DATA_TOGGLE_EN
    localparam logic [7:0] PID_D1 = 8'h4B;
`else
    localparam logic [7:0] PID_D1 = 8'hC3;
`endif

    typedef struct {
        logic [1:0] pkt;
        logic [6:0] occ;
        logic       clr;
        logic [7:0] base;
        logic [7:0] pid;
        int         gets;
        int         cycles;
    } vec_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [1:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic       clear_toggle;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       dplus_out;
    logic       dminus_out;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] buf_q[$];
    logic [1:0] sb_q[$];
    vec_t       vecs[11];

    usb_tx_encoder #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_start           (tx_start),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .clear_toggle       (clear_toggle),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_packet(input vec_t v);
        logic       raw[$];
        logic       st[$];
        logic [7:0] sync_byte;
        logic [7:0] b;
        logic [15:0] crc;
        logic       fb;
        logic       j;
        logic [1:0] exp_line;
        int         n, ones, cyc, act_cyc, gets, exp_cyc;

        n = (v.pkt == 2'd2) ? int'(v.occ) : 0;
        buf_q.delete();
        for (int i = 0; i < n; i++)
            buf_q.push_back(v.base ^ 8'(i * 53));
        tx_packet_data = (n > 0) ? buf_q[0] : 8'h00;

        sync_byte = 8'h80;
        for (int i = 0; i < 8; i++) raw.push_back(sync_byte[i]);
        for (int i = 0; i < 8; i++) raw.push_back(v.pid[i]);
        crc = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            b = buf_q[k];
            for (int i = 0; i < 8; i++) begin
                raw.push_back(b[i]);
                fb  = b[i] ^ crc[15];
                crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        if (v.pkt == 2'd2)
            for (int i = 15; i >= 0; i--) raw.push_back(~crc[i]);
        ones = 0;
        for (int i = 0; i < raw.size(); i++) begin
            st.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                st.push_back(1'b0);
                ones = 0;
            end
        end
        sb_q.delete();
        j = 1'b1;
        for (int i = 0; i < st.size(); i++) begin
            if (!st[i]) j = ~j;
            sb_q.push_back(j ? 2'b10 : 2'b01);
        end
        sb_q.push_back(2'b00);
        sb_q.push_back(2'b00);
        sb_q.push_back(2'b10);
        exp_cyc = (v.cycles != 0) ? v.cycles : sb_q.size() * CPB;

        if (v.clr) begin
            @(negedge clk) clear_toggle = 1'b1;
            @(negedge clk) clear_toggle = 1'b0;
        end
        @(negedge clk);
        tx_packet        = v.pkt;
        buffer_occupancy = v.occ;
        tx_start         = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("active_rise", tx_transfer_active, 1);
        cyc = 0; act_cyc = 0; gets = 0;
        while (tx_transfer_active && cyc < 4000) begin
            act_cyc++;
            if (get_tx_packet_data) begin
                gets++;
                if (buf_q.size() > 0) void'(buf_q.pop_front());
                tx_packet_data = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
            end
            if (cyc % CPB == CPB / 2) begin
                exp_line = (sb_q.size() > 0) ? sb_q.pop_front() : 2'b11;
                check("line_bit", {dplus_out, dminus_out}, exp_line);
            end
            cyc++;
            @(negedge clk);
        end
        check("bits_left", sb_q.size(), 0);
        check("active_cycles", act_cyc, exp_cyc);
        check("get_pulses", gets, v.gets);
        check("idle_line", {dplus_out, dminus_out}, 2'b10);
    endtask

    initial begin
        int gets, cyc;
        vec_t a;

        vecs[0]  = '{2'd0, 7'd0,   1'b0, 8'h00, 8'hD2, 0,  76};
        vecs[1]  = '{2'd1, 7'd0,   1'b0, 8'h00, 8'h5A, 0,  76};
        vecs[2]  = '{2'd3, 7'd0,   1'b0, 8'h00, 8'h1E, 0,  76};
        vecs[3]  = '{2'd2, 7'd2,   1'b0, 8'h3C, 8'hC3, 2,  0};
        vecs[4]  = '{2'd2, 7'd2,   1'b0, 8'hA5, PID_D1, 2, 0};
        vecs[5]  = '{2'd2, 7'd2,   1'b1, 8'h00, 8'hC3, 2,  0};
        vecs[6]  = '{2'd2, 7'd2,   1'b1, 8'h7E, 8'hC3, 2,  0};
        vecs[7]  = '{2'd2, 7'd0,   1'b1, 8'h00, 8'hC3, 0,  140};
        vecs[8]  = '{2'd2, 7'd1,   1'b1, 8'hFF, 8'hC3, 1,  0};
        vecs[9]  = '{2'd0, 7'd100, 1'b0, 8'h00, 8'hD2, 0,  76};
        vecs[10] = '{2'd2, 7'd64,  1'b0, 8'h5A, PID_D1, 64, 0};

        n_rst            = 1'b0;
        tx_start         = 1'b0;
        tx_packet        = 2'd0;
        buffer_occupancy = 7'd0;
        clear_toggle     = 1'b0;
        tx_packet_data   = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_line", {dplus_out, dminus_out}, 2'b10);
        check("rst_active", tx_transfer_active, 0);
        check("rst_error", tx_error, 0);
        check("rst_get", get_tx_packet_data, 0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_packet(vecs[i]);
            check("no_error", tx_error, 0);
        end

        @(negedge clk);
        tx_packet        = 2'd2;
        buffer_occupancy = 7'd65;
        tx_start         = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("err_set", tx_error, 1);
        check("err_active", tx_transfer_active, 0);
        check("err_line", {dplus_out, dminus_out}, 2'b10);
        repeat (8) @(negedge clk);
        check("err_sticky", tx_error, 1);
        check("err_hold_line", {dplus_out, dminus_out}, 2'b10);
        check("err_hold_active", tx_transfer_active, 0);
        a = '{2'd0, 7'd0, 1'b0, 8'h00, 8'hD2, 0, 76};
        run_packet(a);
        check("err_cleared", tx_error, 0);

        buf_q.delete();
        for (int i = 0; i < 4; i++) buf_q.push_back(8'h11 * 8'(i + 1));
        tx_packet_data = buf_q[0];
        @(negedge clk);
        tx_packet        = 2'd2;
        buffer_occupancy = 7'd4;
        tx_start         = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        gets = 0; cyc = 0;
        while (gets < 2 && cyc < 2000) begin
            if (get_tx_packet_data) begin
                gets++;
                void'(buf_q.pop_front());
                tx_packet_data = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
            end
            cyc++;
            @(negedge clk);
        end
        check("rst_reached_payload", gets, 2);
        repeat (5) @(negedge clk);
        check("rst_pre_active", tx_transfer_active, 1);
        #1 n_rst = 1'b0;
        #1;
        check("rst_async_line", {dplus_out, dminus_out}, 2'b10);
        check("rst_async_active", tx_transfer_active, 0);
        gets = 0;
        repeat (4) begin
            @(negedge clk);
            if (get_tx_packet_data) gets++;
        end
        check("rst_no_get", gets, 0);
        n_rst = 1'b1;
        buf_q.delete();
        tx_packet_data = 8'h00;
        @(negedge clk);
        run_packet(a);
        check("post_rst_error", tx_error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

USB full-speed transmit encoder for the endpoint's AHB-Lite slave path. Accepts a packet request (ACK, NAK, DATA, STALL) from the register block, fetches payload bytes from the endpoint data buffer, and serialises SYNC, PID, payload and CRC16. Applies bit stuffing, NRZI and EOP, and drives the D+/D− pins. Reports `tx_transfer_active` and `tx_error` back to the register block.

## Interface
- `CLKS_PER_BIT`, default 4: clk cycles per USB bit time (48 MHz clk → 12 Mb/s).
- `MAX_PAYLOAD`, default 64: largest legal DATA payload in bytes.
- `clk` in 1: system clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `tx_start` in 1: one-cycle request; sampled only in IDLE.
- `tx_packet` in 2: packet type, sampled with `tx_start`: 0 ACK, 1 NAK, 2 DATA, 3 STALL.
- `buffer_occupancy` in 7: bytes held in the data buffer; sampled with `tx_start`.
- `clear_toggle` in 1: forces the next DATA PID to DATA0.
- `tx_packet_data` in 8: head byte of the show-ahead data buffer.
- `get_tx_packet_data` out 1: one-cycle pop strobe to the buffer.
- `tx_transfer_active` out 1: high from the first SYNC bit through the final J of EOP.
- `tx_error` out 1: sticky DATA request error.
- `dplus_out` out 1: D+ line.
- `dminus_out` out 1: D− line.

## Operation
- Reset values:
  - `dplus_out`=1, `dminus_out`=0 (J).
  - `tx_transfer_active`=0, `tx_error`=0, `get_tx_packet_data`=0.
  - Data toggle=0, state=IDLE.
- States: IDLE → SYNC → PID → (DATA → CRC, DATA packets only) → EOP → IDLE.
- SYNC: 8'h80 sent LSB first (seven 0s, then a 1).
- PID byte: {~pid, pid}, sent LSB first.
  - ACK pid=4'b0010, NAK 4'b1010, STALL 4'b1110.
  - DATA0 4'b0011, DATA1 4'b1011.
- DATA request with sampled occupancy > `MAX_PAYLOAD`:
  - Set `tx_error`, send nothing, stay in IDLE.
  - `tx_error` clears on the next accepted `tx_start`.
- Payload length = sampled occupancy (0..64). A zero-length payload goes straight PID → CRC.
- Byte fetch: each payload byte is taken from `tx_packet_data` on the cycle `get_tx_packet_data` is high. The strobe fires once per byte, on the first cycle of that byte's first bit time.
- Payload bits go out LSB first.
- CRC16:
  - Register seeded 16'hFFFF at PID end.
  - Per payload bit b: fb=b^c[15]; c={c[14:0],1'b0}^(fb?16'h8005:16'h0).
  - Transmit ~c[15] down to ~c[0].
- Bit stuffing:
  - A ones counter runs over SYNC, PID, payload and CRC bits (pre-NRZI).
  - After six consecutive 1s, insert one 0 bit time. The data shift and CRC hold during the inserted bit.
  - The counter resets on any 0, including the stuffed 0. It does not run during EOP.
- NRZI: a 0 toggles the J/K line state; a 1 holds it. The line is J before SYNC.
- EOP: SE0 (both lines 0) for 2 bit times, then J for 1 bit time, then IDLE.
- Data toggle:
  - Flips after each completed DATA packet.
  - `clear_toggle` forces it to 0 and has priority over the flip in the same cycle.
- `tx_start` outside IDLE is ignored.
- `tx_packet` ≠ DATA ignores `buffer_occupancy`.

## Timing
- `tx_start` high at edge k → `tx_transfer_active`=1 and the first SYNC bit on the lines from edge k+1.
- Every bit time, including stuffed and EOP bits, is exactly `CLKS_PER_BIT` cycles.
- Unstuffed packet length in cycles = `CLKS_PER_BIT`·(8+8+8·N+16·isData+3).
- `tx_transfer_active` falls on the edge ending the EOP J bit. A new `tx_start` is accepted on that same cycle.
- `n_rst` low mid-packet:
  - Lines return to J and `tx_transfer_active` drops immediately (asynchronously).
  - No further `get_tx_packet_data` strobes are issued.

## Configuration
- `USB_TX_DATA_TOGGLE_EN`:
  - Defined: DATA PID alternates DATA0/DATA1 as described above.
  - Undefined: every DATA packet uses DATA0; the toggle register and `clear_toggle` logic are removed, and the port is left unused.

## Test plan
- ACK: `tx_start`, `tx_packet`=0.
  - Lines show SYNC then PID 8'hD2 NRZI-encoded, with no stuffing.
  - `tx_transfer_active` high for exactly 76 cycles.
- Zero-length DATA0: `tx_packet`=2, occupancy 0.
  - PID 8'hC3, CRC bits all 0, zero `get_tx_packet_data` pulses.
  - Active for 140 cycles.
- One-byte DATA, byte 8'hFF:
  - Exactly 1 `get_tx_packet_data` pulse.
  - A stuffed 0 appears after the 4th payload bit.
  - Decoded CRC matches the reference model.
- Occupancy 65 with DATA:
  - `tx_error`=1 on the next cycle; lines stay J; `tx_transfer_active` stays 0.
  - Next ACK request clears `tx_error`.
- Two back-to-back DATA packets (occupancy 2 each):
  - PIDs are DATA0 then DATA1 with the macro defined, DATA0 twice without it.
  - Asserting `clear_toggle` between packets yields DATA0 twice.
- `n_rst` pulsed during payload:
  - Outputs immediately J, `tx_transfer_active`=0.
  - Following ACK request transmits normally.
